// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB fade control path.
// Colour width, saturation value and fade FSM state encodings.
package rgb_pkg;

  localparam int RGB_W = 8;
  localparam logic [RGB_W-1:0] RGB_MAX = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_UP   = 3'd2,
    ST_DOWN = 3'd3,
    ST_DONE = 3'd4
  } fade_state_e;

endpackage

// File: rtl/rgb_step_timer.sv
// Phase step counter shared by the ramp-up and ramp-down phases; clear has priority over enable.
// tc is combinational from the registered count, so the FSM can leave a phase on its last cycle.
module rgb_step_timer #(
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [STEP_W-1:0] term,
  output logic [STEP_W-1:0] cnt,
  output logic              tc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

  assign tc = en && (cnt == term);

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Fade controller for RGB_processor: load colour, add phase, subtract phase, repeat per loop count.
// Start-to-load-strobe latency 1 clk; all outputs registered from the next-state decode.
module rgb_fade_sequencer
  import rgb_pkg::*;
#(
  parameter int UP_STEPS   = 16,
  parameter int DOWN_STEPS = 16,
  parameter int STEP_W     = 8,
  parameter int LOOP_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [RGB_W-1:0]  cfg_r,
  input  logic [RGB_W-1:0]  cfg_g,
  input  logic [RGB_W-1:0]  cfg_b,
  input  logic [LOOP_W-1:0] cfg_loops,
  input  logic [RGB_W-1:0]  fb_r,
  input  logic [RGB_W-1:0]  fb_g,
  input  logic [RGB_W-1:0]  fb_b,
  output logic [RGB_W-1:0]  r_in,
  output logic [RGB_W-1:0]  g_in,
  output logic [RGB_W-1:0]  b_in,
  output logic              write_enable_init,
  output logic              s,
  output logic              busy,
  output logic              done,
  output logic [LOOP_W-1:0] loop_cnt,
  output logic [2:0]        state_o
);

  localparam logic [STEP_W-1:0] UP_TERM   = STEP_W'(UP_STEPS - 1);
  localparam logic [STEP_W-1:0] DOWN_TERM = STEP_W'(DOWN_STEPS - 1);

  fade_state_e       state_q, state_nxt;
  logic [LOOP_W-1:0] cfg_loops_q;
  logic [LOOP_W-1:0] loop_inc;
  logic [STEP_W-1:0] step_cnt;
  logic [STEP_W-1:0] step_term;
  logic              step_tc, tmr_en, tmr_clr;
  logic              up_guard, down_guard;
  logic              start_acc, down_exit;

  assign tmr_en    = (state_q == ST_UP) || (state_q == ST_DOWN);
  assign tmr_clr   = (state_nxt != state_q) || !tmr_en;
  assign step_term = (state_q == ST_DOWN) ? DOWN_TERM : UP_TERM;

  rgb_step_timer #(.STEP_W(STEP_W)) u_step_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .term (step_term),
    .cnt  (step_cnt),
    .tc   (step_tc)
  );

  // Feedback in the first cycle of a phase still reflects the previous phase, so guards wait one step.
  assign up_guard   = (step_cnt != '0) &&
                      ((fb_r == RGB_MAX) || (fb_g == RGB_MAX) || (fb_b == RGB_MAX));
  assign down_guard = (step_cnt != '0) && (fb_r == '0) && (fb_g == '0) && (fb_b == '0);

  assign loop_inc  = loop_cnt + 1'b1;
  assign start_acc = (state_q == ST_IDLE) && start && !abort;
  assign down_exit = (state_q == ST_DOWN) && (step_tc || down_guard) && !abort;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_UP;
      ST_UP:   if (step_tc || up_guard) state_nxt = ST_DOWN;
      ST_DOWN: begin
        if (step_tc || down_guard) begin
          if ((cfg_loops_q != '0) && (loop_inc == cfg_loops_q))
            state_nxt = ST_DONE;
          else
            state_nxt = ST_UP;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (abort)
      state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      write_enable_init <= 1'b0;
      s                 <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      r_in              <= '0;
      g_in              <= '0;
      b_in              <= '0;
      cfg_loops_q       <= '0;
      loop_cnt          <= '0;
    end else begin
      state_q           <= state_nxt;
      write_enable_init <= (state_nxt == ST_LOAD);
      s                 <= (state_nxt == ST_DOWN);
      busy              <= (state_nxt != ST_IDLE);
      done              <= (state_nxt == ST_DONE);
      if (start_acc) begin
        r_in        <= cfg_r;
        g_in        <= cfg_g;
        b_in        <= cfg_b;
        cfg_loops_q <= cfg_loops;
        loop_cnt    <= '0;
      end else if (down_exit) begin
        loop_cnt <= loop_inc;
      end
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer: a per-cycle vector table plus hand-built multi-cycle sequences.
module tb_rgb_fade_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_UP = 3'd2, S_DOWN = 3'd3, S_DONE = 3'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort;
  logic [7:0] cfg_r, cfg_g, cfg_b;
  logic [3:0] cfg_loops;
  logic [7:0] fb_r, fb_g, fb_b;
  logic [7:0] r_in, g_in, b_in;
  logic       write_enable_init, s, busy, done;
  logic [3:0] loop_cnt;
  logic [2:0] state_o;

  int tests = 0;
  int failed = 0;
  int done_pulses = 0;

  always #5 clk = ~clk;

  rgb_fade_sequencer #(.UP_STEPS(16), .DOWN_STEPS(16), .STEP_W(8), .LOOP_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_r(cfg_r), .cfg_g(cfg_g), .cfg_b(cfg_b), .cfg_loops(cfg_loops),
    .fb_r(fb_r), .fb_g(fb_g), .fb_b(fb_b),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .write_enable_init(write_enable_init), .s(s), .busy(busy), .done(done),
    .loop_cnt(loop_cnt), .state_o(state_o)
  );

  typedef struct {
    logic       start;
    logic       abort;
    logic [7:0] cfg_r;
    logic [7:0] fb_g;
    logic [2:0] st;
    logic       we;
    logic       s;
    logic       busy;
    logic       done;
    logic [3:0] lc;
    logic [7:0] rin;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    if (done === 1'b1) done_pulses++;
  endtask

  // Stays in one state while checking its outputs each cycle; reports cycle count and bad cycles.
  task automatic run_phase(input logic [2:0] st, input logic exp_s, output int len, output int bad);
    len = 0;
    bad = 0;
    while (state_o === st && len < 40) begin
      if (s !== exp_s || write_enable_init !== 1'b0 || busy !== 1'b1 || done !== 1'b0) bad++;
      tick();
      len++;
    end
  endtask

  task automatic check_phase(input string name, input logic [2:0] st, input logic exp_s, input int exp_len);
    int len, bad;
    run_phase(st, exp_s, len, bad);
    chk({name, "_len"}, len, exp_len);
    chk({name, "_outs"}, bad, 0);
  endtask

  task automatic begin_run(input logic [3:0] loops);
    cfg_r = 8'd10; cfg_g = 8'd20; cfg_b = 8'd30; cfg_loops = loops;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  vec_t tbl [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int len, bad, lc_bad;

    tbl[0] = '{1'b1, 1'b1, 8'd10, 8'h80, S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
    tbl[1] = '{1'b1, 1'b0, 8'd10, 8'h80, S_LOAD, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 8'd10};
    tbl[2] = '{1'b0, 1'b0, 8'd10, 8'h80, S_UP,   1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd10};
    tbl[3] = '{1'b1, 1'b0, 8'd99, 8'hFF, S_UP,   1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd10};
    tbl[4] = '{1'b0, 1'b1, 8'd99, 8'h80, S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd10};
    tbl[5] = '{1'b0, 1'b0, 8'd99, 8'h80, S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd10};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_r = 8'd0; cfg_g = 8'd20; cfg_b = 8'd30; cfg_loops = 4'd2;
    fb_r = 8'h80; fb_g = 8'h80; fb_b = 8'h80;
    repeat (2) tick();
    chk("rst_state", state_o, S_IDLE);
    chk("rst_outs", {write_enable_init, s, busy, done}, 4'b0000);
    chk("rst_rgb", {r_in, g_in, b_in}, 24'd0);
    chk("rst_loop", loop_cnt, 0);
    rst = 1'b0;
    tick();

    // Per-cycle table: abort beats start in IDLE, load strobe, start ignored while busy, abort.
    for (int i = 0; i < 6; i++) begin
      start = tbl[i].start; abort = tbl[i].abort; cfg_r = tbl[i].cfg_r; fb_g = tbl[i].fb_g;
      tick();
      chk($sformatf("vec%0d_state", i), state_o, tbl[i].st);
      chk($sformatf("vec%0d_outs", i), {write_enable_init, s, busy, done},
          {tbl[i].we, tbl[i].s, tbl[i].busy, tbl[i].done});
      chk($sformatf("vec%0d_loop", i), loop_cnt, tbl[i].lc);
      chk($sformatf("vec%0d_rin", i), r_in, tbl[i].rin);
    end
    start = 1'b0; abort = 1'b0; fb_g = 8'h80;

    // Two full loops at mid feedback.
    begin_run(4'd2);
    chk("a_load", {state_o, write_enable_init, s, busy}, {S_LOAD, 3'b101});
    chk("a_rgb", {r_in, g_in, b_in}, {8'd10, 8'd20, 8'd30});
    tick();
    check_phase("a_up0", S_UP, 1'b0, 16);
    check_phase("a_dn0", S_DOWN, 1'b1, 16);
    chk("a_loop1", loop_cnt, 1);
    check_phase("a_up1", S_UP, 1'b0, 16);
    check_phase("a_dn1", S_DOWN, 1'b1, 16);
    chk("a_done", {state_o, done, busy, s}, {S_DONE, 3'b110});
    chk("a_loop2", loop_cnt, 2);
    tick();
    chk("a_idle", {state_o, done, busy}, {S_IDLE, 2'b00});
    chk("a_loop_hold", loop_cnt, 2);
    chk("a_done_once", done_pulses, 1);

    // Saturation guard in UP, zero guard in DOWN, single-loop completion.
    begin_run(4'd1);
    tick();
    fb_g = 8'hFF;
    tick();
    chk("b_up_step0_ignore", state_o, S_UP);
    fb_g = 8'h80;
    repeat (2) tick();
    fb_g = 8'hFF;
    tick();
    chk("b_up_guard", {state_o, s}, {S_DOWN, 1'b1});
    fb_r = 8'h00; fb_g = 8'h00; fb_b = 8'h00;
    tick();
    chk("b_dn_step0_ignore", state_o, S_DOWN);
    fb_r = 8'h80; fb_g = 8'h80; fb_b = 8'h80;
    repeat (3) tick();
    fb_r = 8'h00; fb_g = 8'h00; fb_b = 8'h00;
    tick();
    chk("b_dn_guard", {state_o, done, s}, {S_DONE, 2'b10});
    chk("b_loop", loop_cnt, 1);
    fb_r = 8'h80; fb_g = 8'h80; fb_b = 8'h80;
    tick();
    chk("b_idle", state_o, S_IDLE);

    // Abort at DOWN step 7.
    begin_run(4'd3);
    tick();
    check_phase("c_up", S_UP, 1'b0, 16);
    repeat (7) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("c_abort", {state_o, busy, s, done, write_enable_init}, {S_IDLE, 4'b0000});
    chk("c_loop_hold", loop_cnt, 0);
    chk("c_no_done", done_pulses, 2);

    // Endless run with start held high: loop counter wraps and DONE never comes.
    begin_run(4'd0);
    start = 1'b1;
    tick();
    lc_bad = 0;
    for (int l = 0; l < 20; l++) begin
      run_phase(S_UP, 1'b0, len, bad);
      if (len != 16 || bad != 0) lc_bad++;
      run_phase(S_DOWN, 1'b1, len, bad);
      if (len != 16 || bad != 0) lc_bad++;
      if (loop_cnt !== 4'((l + 1) % 16)) lc_bad++;
      if (l == 15) chk("d_wrap", loop_cnt, 0);
    end
    chk("d_loops", lc_bad, 0);
    chk("d_still_up", {state_o, busy}, {S_UP, 1'b1});
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("d_abort", {state_o, busy}, {S_IDLE, 1'b0});
    chk("d_loop_final", loop_cnt, 4);
    chk("d_no_done", done_pulses, 2);

    // Asynchronous reset at UP step 5, then a clean run proves the step counter was cleared.
    begin_run(4'd2);
    tick();
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    chk("e_rst_state", state_o, S_IDLE);
    chk("e_rst_outs", {write_enable_init, s, busy, done}, 4'b0000);
    chk("e_rst_vals", {r_in, g_in, b_in, 4'b0000, loop_cnt}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("e_no_done", done_pulses, 2);
    begin_run(4'd1);
    tick();
    check_phase("e_up", S_UP, 1'b0, 16);
    check_phase("e_dn", S_DOWN, 1'b1, 16);
    chk("e_done", {state_o, done}, {S_DONE, 1'b1});
    tick();
    chk("e_done_total", done_pulses, 3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
